// File: rtl/inst_package.sv
// rtl/inst_package.sv - shared opcodes, NOP bundle and fetch state type for fetch/decode
package inst_package;

  localparam logic [5:0]  OP_NOP = 6'h00;
  localparam logic [5:0]  OP_ADD = 6'h01;
  localparam logic [5:0]  OP_END = 6'h3F;

  localparam logic [63:0] NOP_BUNDLE = {OP_NOP, 26'b0, OP_NOP, 26'b0};

  typedef enum logic [1:0] {F_IDLE, F_RUN, F_HALT} fetch_state_t;

  // End is carried in the upper slot only
  function automatic logic is_end_bundle(input logic [63:0] bundle);
    return bundle[63:58] == OP_END;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating performance counter with enable and sync clear
module fetch_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt <= '0;
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: BRAM addressing, interlock replay, redirect, halt on End
module fetch_unit
  import inst_package::*;
#(
  parameter int IMEM_AW  = 15,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               go,
  input  logic               interlock,
  input  logic               branch_flag,
  input  logic [31:0]        branch_pc,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [63:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [63:0]        inst,
  output logic               halted,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   redirect_cnt
);

  fetch_state_t       state;
  logic [IMEM_AW-1:0] req_pc;
  logic               valid;
  logic [IMEM_AW-1:0] next_addr;
  logic               in_run;
  logic               accept;
  logic               end_accept;
  logic               unused_branch_hi;

  assign unused_branch_hi = ^branch_pc[31:IMEM_AW];

  assign in_run     = (state == F_RUN);
  assign accept     = in_run && valid && !interlock && !branch_flag;
  assign end_accept = accept && is_end_bundle(imem_rdata);

  // An accepted End stops issuing so the BRAM output stays on the End bundle
  always_comb begin
    imem_en   = 1'b0;
    next_addr = req_pc;
    case (state)
      F_IDLE: begin
        imem_en   = go;
        next_addr = IMEM_AW'(RESET_PC);
      end
      F_RUN: begin
        imem_en = !end_accept;
        if (branch_flag) begin
          next_addr = branch_pc[IMEM_AW-1:0];
        end else if (interlock) begin
          next_addr = req_pc;
        end else if (valid && !end_accept) begin
          next_addr = req_pc + IMEM_AW'(1);
        end
      end
      default: begin
        imem_en   = 1'b0;
        next_addr = req_pc;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= F_IDLE;
      req_pc <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        F_IDLE: begin
          if (go) begin
            state  <= F_RUN;
            req_pc <= next_addr;
            valid  <= 1'b1;
          end
        end
        F_RUN: begin
          req_pc <= next_addr;
          valid  <= 1'b1;
          if (end_accept) begin
            state <= F_HALT;
          end
        end
        default: state <= F_HALT;
      endcase
    end
  end

  assign imem_addr = next_addr;
  assign pc        = {{(32-IMEM_AW){1'b0}}, req_pc};
  assign inst      = valid ? imem_rdata : NOP_BUNDLE;
  assign halted    = (state == F_HALT);

  fetch_perf_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk (clk),
    .rstn(rstn),
    .clr (1'b0),
    .en  (in_run),
    .cnt (cyc_cnt)
  );

  fetch_perf_cnt #(.CNT_W(CNT_W)) u_fetch_cnt (
    .clk (clk),
    .rstn(rstn),
    .clr (1'b0),
    .en  (accept),
    .cnt (fetch_cnt)
  );

  fetch_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rstn(rstn),
    .clr (1'b0),
    .en  (in_run && interlock && !branch_flag),
    .cnt (stall_cnt)
  );

  fetch_perf_cnt #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk (clk),
    .rstn(rstn),
    .clr (1'b0),
    .en  (in_run && branch_flag),
    .cnt (redirect_cnt)
  );

endmodule
